dmem_responder: RTL and testbench



---
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// M-stage data memory bus: request from the pipeline, response from the responder.
interface dmem_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        RespValidM;
  logic        MemErrM;

  modport master (
    output MemReqM, MemWriteM, ALUResultM, WriteDataM, ByteEnM,
    input  ReadDataM, MemStallM, RespValidM, MemErrM
  );

  modport slave (
    input  MemReqM, MemWriteM, ALUResultM, WriteDataM, ByteEnM,
    output ReadDataM, MemStallM, RespValidM, MemErrM
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: one load/store per request, with a
// programmable number of wait states, byte-lane stores and range faulting.
//
// state | meaning
// IDLE  | waiting for MemReqM; request fields are latched on acceptance
// BUSY  | wait-state down-counter running; commit when it reaches zero
// DONE  | response cycle (RespValidM=1); always back to IDLE next cycle
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic        weQ;
  logic [3:0]  beQ;
  logic [31:0] readDataQ;
  logic        respValidQ;
  logic        memErrQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] wordIdx;
  logic          fault;
  logic          commit;
  logic          memWe;
  logic          unusedOff;

  // Byte offset from the array base; wrap below the base lands far out of range.
  assign off       = addrQ - ADDR_BASE;
  assign wordIdx   = off[AW+1:2];
  // Low address bits do not select anything: lanes come from ByteEnM.
  assign unusedOff = ^off[1:0];
  assign fault     = (|(off >> (AW + 2))) || (weQ && (beQ == 4'b0000));

  assign commit = (state == BUSY) && (cnt == 4'd0);
  // Reset in the commit cycle must suppress the write.
  assign memWe  = commit && weQ && !fault && !reset;

  assign bus.MemStallM  = ((state == IDLE) && bus.MemReqM) || (state == BUSY);
  assign bus.RespValidM = respValidQ;
  assign bus.ReadDataM  = readDataQ;
  assign bus.MemErrM    = memErrQ;

  // Storage array: lane-masked write at commit.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (beQ[i]) mem[wordIdx][8*i +: 8] <= wdataQ[8*i +: 8];
      end
    end
  end

  // Request sequencing FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addrQ      <= 32'd0;
      wdataQ     <= 32'd0;
      weQ        <= 1'b0;
      beQ        <= 4'd0;
      readDataQ  <= 32'd0;
      respValidQ <= 1'b0;
      memErrQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MemReqM) begin
            addrQ  <= bus.ALUResultM;
            wdataQ <= bus.WriteDataM;
            weQ    <= bus.MemWriteM;
            beQ    <= bus.ByteEnM;
            cnt    <= 4'(WAIT_STATES);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= DONE;
            respValidQ <= 1'b1;
            memErrQ    <= fault;
            readDataQ  <= (!weQ && !fault) ? mem[wordIdx] : 32'd0;
          end
        end
        DONE: begin
          // MemReqM is still the retiring request here, so it is ignored.
          state      <= IDLE;
          respValidQ <= 1'b0;
          memErrQ    <= 1'b0;
          readDataQ  <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance at base 0 and a
// 0-wait-state instance at base 0x1000, checked against a small memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    bit          e;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] modelMem [2][256];

  always #5 clk = ~clk;

  dmem_if bus2();
  dmem_if bus0();

  assign bus2.MemReqM    = req & ~sel;
  assign bus2.MemWriteM  = we;
  assign bus2.ALUResultM = addr;
  assign bus2.WriteDataM = wdata;
  assign bus2.ByteEnM    = be;
  assign bus0.MemReqM    = req & sel;
  assign bus0.MemWriteM  = we;
  assign bus0.ALUResultM = addr;
  assign bus0.WriteDataM = wdata;
  assign bus0.ByteEnM    = be;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_BASE(32'h0000_0000)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h0000_1000)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  logic        respV, stallV, errV;
  logic [31:0] rdV;
  assign respV  = sel ? bus0.RespValidM : bus2.RespValidM;
  assign stallV = sel ? bus0.MemStallM  : bus2.MemStallM;
  assign errV   = sel ? bus0.MemErrM    : bus2.MemErrM;
  assign rdV    = sel ? bus0.ReadDataM  : bus2.ReadDataM;

  // Reference model: word array per instance, fault rules, store returns 0.
  task automatic predict(input bit s, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         output logic [31:0] d, output bit e);
    logic [31:0] o;
    o = a - (s ? 32'h0000_1000 : 32'h0000_0000);
    e = (o[31:2] > 30'd255) || (w && (b == 4'b0000));
    d = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) modelMem[s][o[9:2]][8*i +: 8] = wd[8*i +: 8];
      end else begin
        d = modelMem[s][o[9:2]];
      end
    end
  endtask

  // Drive one request, push its prediction, wait (bounded) for the response and pop.
  task automatic runReq(input bit s, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input bit churn,
                        output int stalls, output int lat,
                        output logic [31:0] gotD, output bit gotE,
                        output logic [31:0] expD, output bit expE, output bit tmo);
    exp_t        x;
    logic [31:0] pd;
    bit          pe;
    @(posedge clk); #1;
    sel = s; we = w; addr = a; wdata = wd; be = b; req = 1'b1;
    predict(s, w, a, wd, b, pd, pe);
    x.d = pd; x.e = pe;
    sbq.push_back(x);
    stalls = 0; lat = -1; tmo = 1'b1; gotD = 32'h0; gotE = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (respV) begin
        lat = k; gotD = rdV; gotE = errV; tmo = 1'b0;
        break;
      end
      if (stallV) stalls++;
      if (churn && k >= 1) begin
        addr  = $urandom;
        wdata = $urandom;
      end
    end
    x = sbq.pop_front();
    expD = x.d; expE = x.e;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; sel = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus2.RespValidM !== 1'b0) begin errors++; $display("FAIL reset_resp2 got=%b want=0", bus2.RespValidM); end
    checks++; if (bus2.ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata2 got=%h want=0", bus2.ReadDataM); end
    checks++; if (bus2.MemErrM !== 1'b0) begin errors++; $display("FAIL reset_err2 got=%b want=0", bus2.MemErrM); end
    checks++; if (bus2.MemStallM !== 1'b0) begin errors++; $display("FAIL reset_stall2 got=%b want=0", bus2.MemStallM); end
    checks++; if (bus0.RespValidM !== 1'b0) begin errors++; $display("FAIL reset_resp0 got=%b want=0", bus0.RespValidM); end
    checks++; if (bus0.MemStallM !== 1'b0) begin errors++; $display("FAIL reset_stall0 got=%b want=0", bus0.MemStallM); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    bit          tw[3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ta[3] = '{32'h10, 32'h10, 32'h10};
    logic [31:0] td[3] = '{32'hDEADBEEF, 32'h0, 32'h0};
    logic [3:0]  tb[3] = '{4'hF, 4'hF, 4'h1};
    int st, lt; logic [31:0] gd, ed; bit ge, ee, to;
    for (int i = 0; i < 3; i++) begin
      runReq(1'b0, tw[i], ta[i], td[i], tb[i], 1'b0, st, lt, gd, ge, ed, ee, to);
      checks++;
      if (to) begin errors++; $display("FAIL store_load_timeout req=%0d got=no_response want=response", i); end
      else begin
        checks++; if (st != 4) begin errors++; $display("FAIL store_load_stall req=%0d got=%0d want=4", i, st); end
        checks++; if (lt != 4) begin errors++; $display("FAIL store_load_latency req=%0d got=%0d want=4", i, lt); end
        checks++; if (gd !== ed) begin errors++; $display("FAIL store_load_data req=%0d got=%h want=%h", i, gd, ed); end
        checks++; if (ge !== ee) begin errors++; $display("FAIL store_load_err req=%0d got=%b want=%b", i, ge, ee); end
      end
    end
    checks++; if (gd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_load_final got=%h want=deadbeef", gd); end
  endtask

  task automatic test_partial_write();
    bit          tw[3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] td[3] = '{32'h11223344, 32'h0000AA00, 32'h0};
    logic [3:0]  tb[3] = '{4'hF, 4'h2, 4'hF};
    int st, lt; logic [31:0] gd, ed; bit ge, ee, to;
    for (int i = 0; i < 3; i++) begin
      runReq(1'b0, tw[i], 32'h20, td[i], tb[i], 1'b0, st, lt, gd, ge, ed, ee, to);
      checks++;
      if (to) begin errors++; $display("FAIL partial_timeout req=%0d got=no_response want=response", i); end
      else begin
        checks++; if (gd !== ed) begin errors++; $display("FAIL partial_data req=%0d got=%h want=%h", i, gd, ed); end
        checks++; if (ge !== ee) begin errors++; $display("FAIL partial_err req=%0d got=%b want=%b", i, ge, ee); end
      end
    end
    checks++; if (gd !== 32'h1122AA44) begin errors++; $display("FAIL partial_final got=%h want=1122aa44", gd); end
  endtask

  task automatic test_fault();
    bit          tw[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ta[7] = '{32'h0, 32'h30, 32'h400, 32'h400, 32'h0, 32'h30, 32'h30};
    logic [31:0] td[7] = '{32'hA5A50001, 32'h77777777, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h12121212, 32'h0};
    logic [3:0]  tb[7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF};
    int st, lt; logic [31:0] gd, ed; bit ge, ee, to;
    for (int i = 0; i < 7; i++) begin
      runReq(1'b0, tw[i], ta[i], td[i], tb[i], 1'b0, st, lt, gd, ge, ed, ee, to);
      checks++;
      if (to) begin errors++; $display("FAIL fault_timeout req=%0d got=no_response want=response", i); end
      else begin
        checks++; if (lt != 4) begin errors++; $display("FAIL fault_latency req=%0d got=%0d want=4", i, lt); end
        checks++; if (gd !== ed) begin errors++; $display("FAIL fault_data req=%0d got=%h want=%h", i, gd, ed); end
        checks++; if (ge !== ee) begin errors++; $display("FAIL fault_err req=%0d got=%b want=%b", i, ge, ee); end
      end
    end
  endtask

  task automatic test_zero_wait();
    bit          tw[3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ta[3] = '{32'h1004, 32'h1004, 32'h0FFC};
    logic [31:0] td[3] = '{32'h0BADF00D, 32'h0, 32'h0};
    int st, lt; logic [31:0] gd, ed; bit ge, ee, to;
    for (int i = 0; i < 3; i++) begin
      runReq(1'b1, tw[i], ta[i], td[i], 4'hF, 1'b0, st, lt, gd, ge, ed, ee, to);
      checks++;
      if (to) begin errors++; $display("FAIL zero_wait_timeout req=%0d got=no_response want=response", i); end
      else begin
        checks++; if (st != 2) begin errors++; $display("FAIL zero_wait_stall req=%0d got=%0d want=2", i, st); end
        checks++; if (lt != 2) begin errors++; $display("FAIL zero_wait_latency req=%0d got=%0d want=2", i, lt); end
        checks++; if (gd !== ed) begin errors++; $display("FAIL zero_wait_data req=%0d got=%h want=%h", i, gd, ed); end
        checks++; if (ge !== ee) begin errors++; $display("FAIL zero_wait_err req=%0d got=%b want=%b", i, ge, ee); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        x;
    logic [31:0] pd;
    bit          pe;
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b0; addr = 32'h1004; wdata = 32'h0; be = 4'hF; req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) begin
        predict(1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, pd, pe);
        x.d = pd; x.e = pe;
        sbq.push_back(x);
      end
      @(negedge clk);
      checks++;
      if (respV !== ((k % 3) == 2)) begin errors++; $display("FAIL b2b_resp cycle=%0d got=%b want=%b", k, respV, ((k % 3) == 2)); end
      checks++;
      if (stallV !== ((k % 3) != 2)) begin errors++; $display("FAIL b2b_stall cycle=%0d got=%b want=%b", k, stallV, ((k % 3) != 2)); end
      if (respV && sbq.size() > 0) begin
        x = sbq.pop_front();
        checks++; if (rdV !== x.d) begin errors++; $display("FAIL b2b_data cycle=%0d got=%h want=%h", k, rdV, x.d); end
      end
    end
    sbq.delete();
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int st, lt; logic [31:0] gd, ed; bit ge, ee, to;
    runReq(1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 1'b0, st, lt, gd, ge, ed, ee, to);
    checks++; if (to) begin errors++; $display("FAIL rst_busy_preload got=no_response want=response"); end
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b1; addr = 32'h8; wdata = 32'h12345678; be = 4'hF; req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    checks++; if (stallV !== 1'b1) begin errors++; $display("FAIL rst_busy_commit_stall got=%b want=1", stallV); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (respV !== 1'b0) begin errors++; $display("FAIL rst_busy_resp cycle=%0d got=%b want=0", k, respV); end
      checks++; if (stallV !== 1'b0) begin errors++; $display("FAIL rst_busy_idle cycle=%0d got=%b want=0", k, stallV); end
    end
    runReq(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, st, lt, gd, ge, ed, ee, to);
    checks++;
    if (to) begin errors++; $display("FAIL rst_busy_timeout got=no_response want=response"); end
    else begin
      checks++; if (gd !== ed) begin errors++; $display("FAIL rst_busy_old_data got=%h want=%h", gd, ed); end
      checks++; if (lt != 4) begin errors++; $display("FAIL rst_busy_latency got=%0d want=4", lt); end
    end
  endtask

  task automatic test_churn();
    bit          tw[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ta[4] = '{32'h40, 32'h40, 32'h1010, 32'h1010};
    logic [31:0] td[4] = '{32'h5A5A1234, 32'h0, 32'h600DCAFE, 32'h0};
    bit          ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int st, lt; logic [31:0] gd, ed; bit ge, ee, to;
    for (int i = 0; i < 4; i++) begin
      runReq(ts[i], tw[i], ta[i], td[i], 4'hF, 1'b1, st, lt, gd, ge, ed, ee, to);
      checks++;
      if (to) begin errors++; $display("FAIL churn_timeout req=%0d got=no_response want=response", i); end
      else begin
        checks++; if (gd !== ed) begin errors++; $display("FAIL churn_data req=%0d got=%h want=%h", i, gd, ed); end
        checks++; if (ge !== ee) begin errors++; $display("FAIL churn_err req=%0d got=%b want=%b", i, ge, ee); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store_load();
    test_partial_write();
    test_fault();
    test_zero_wait();
    test_back_to_back();
    test_reset_mid_busy();
    test_churn();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
